regfile_scan_ctrl: RTL and testbench
====================================

Name: regfile_scan_ctrl

Overview:
- Sequences a full read-out of the processor register file through regfile read port A (the rs1 port), for on-board debug triggered by a push button.
- Sits between the core's rs1 decode and the regfile inside Wrapper.
- Arbitrates port A between the core and the scan engine.
- Streams {index, value} pairs to a debug sink, such as a UART or LED mux.

Parameters:
- NUM_REGS, 32: registers scanned, indices 0..NUM_REGS-1; index width fixed at 5.
- MAX_WAIT, 4: consecutive cycles the scan may be denied before it forces a grant and stalls the core; 0 means the scan always wins.
- SYNC_STAGES, 2: flops in the button synchronizer; minimum 2.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- start_btn  in  1  raw push button (BTND), asynchronous to clock.
- core_rs1  in  5  core's port-A read index.
- core_rs1_req  in  1  core needs port A this cycle.
- regA  in  32  regfile port-A read data; combinational from rs1_in.
- rs1_in  out  5  index driven to regfile port A.
- core_stall  out  1  core must hold its pipeline this cycle.
- dump_valid  out  1  one-cycle strobe: dump_idx/dump_data valid.
- dump_idx  out  5  register index of the dumped value.
- dump_data  out  32  dumped register value.
- busy  out  1  scan in progress (state SCAN or DONE).
- done  out  1  one-cycle pulse when the scan completes.

Behaviour:
- Reset values:
  - state=IDLE; idx=0; wait_cnt=0; synchronizer and edge flop cleared.
  - Registered outputs are all 0: dump_valid, dump_idx, dump_data, done.
- Reset asserted mid-scan aborts the scan immediately; no done pulse follows.
- Start detection:
  - start_btn passes through the SYNC_STAGES flops, then a rising-edge detect produces start_pulse.
  - Button-to-pulse latency is SYNC_STAGES+1 cycles.
  - A held button gives one pulse only.
- States:
  - IDLE: rs1_in=core_rs1, core_stall=0. start_pulse -> SCAN with idx=0, wait_cnt=0.
  - SCAN: grant = !core_rs1_req || (wait_cnt==MAX_WAIT). Combinational outputs: rs1_in = grant ? idx : core_rs1; core_stall = core_rs1_req & grant.
  - SCAN, on posedge with grant: dump_data<=regA, dump_idx<=idx, dump_valid<=1, wait_cnt<=0, idx<=idx+1. If idx==NUM_REGS-1 -> DONE.
  - SCAN, on posedge without grant: dump_valid<=0, wait_cnt<=wait_cnt+1, saturating at MAX_WAIT.
  - DONE: done=1 and busy=1 for exactly one cycle (coinciding with dump_valid of the last register) -> IDLE.
- start_pulse in SCAN or DONE is ignored; no restart and no queueing.
- dump_valid is high for exactly NUM_REGS cycles per scan, in index order 0..NUM_REGS-1, with no duplicates.
- Bubbles appear only when the core wins arbitration.
- dump_data holds its last value between strobes.
- Uncontended scan: first dump_valid 1 cycle after entering SCAN; last at SCAN+NUM_REGS cycles.
- Index 0: the scan reports whatever regfile returns; no special-casing.
- Core writes during a scan are not blocked; a dumped value reflects the regfile at its sampling edge.
- Worst-case core stall: 1 cycle per MAX_WAIT+1 cycles of continuous core_rs1_req; the scan never starves.

Decomposition:
- Shared package holds:
  - State encoding: SCAN_IDLE=2'd0, SCAN_RUN=2'd1, SCAN_DONE=2'd2.
  - REG_IDX_W=5 and DATA_W=32.
- One sub-module, btn_sync_edge (SYNC_STAGES synchronizer plus rising-edge pulse); it is reusable for other Wrapper buttons.
- Arbitration and FSM stay in regfile_scan_ctrl.

Test Plan:
- Idle, core_rs1_req=0 throughout, regfile preloaded with rN=N*3; pulse start_btn for 5 cycles:
  - First dump_valid 4 cycles after the first synchronized high.
  - 32 consecutive strobes with dump_idx 0..31 and dump_data 0,3,..,93.
  - done coincides with idx 31; busy drops the next cycle.
- Scan under core_rs1_req=1 held constant, MAX_WAIT=4, core_rs1=7:
  - Strobes exactly every 5th cycle.
  - core_stall high only on strobe cycles.
  - rs1_in=7 on all other cycles.
  - Total scan 160 cycles.
- MAX_WAIT=0 with core_rs1_req=1: scan completes in 32 cycles with core_stall=1 each cycle.
- Second button press at idx=10: ignored; exactly 32 strobes and one done pulse.
- reset asserted at idx=15 (async, mid-cycle):
  - All outputs 0 immediately; no done pulse.
  - A new press after release restarts at dump_idx=0.
- Button bounce 1-0-1 within 2 cycles while idle: at most one scan started; rs1_in tracks core_rs1 whenever state is IDLE.

Source files
------------

// File: rtl/regfile_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_scan_ctrl_pkg
// Shared definitions for the register-file scan controller: the scan FSM
// state encoding and the index/data widths of the regfile read port.
// ---------------------------------------------------------------------------
package regfile_scan_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        SCAN_IDLE = 2'd0,
        SCAN_RUN  = 2'd1,
        SCAN_DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/regfile_scan_ctrl_btn_sync.sv
// ---------------------------------------------------------------------------
// btn_sync_edge
// Brings a raw, asynchronous push button into the clock domain through a
// SYNC_STAGES-deep flop chain and emits a registered one-cycle pulse on each
// rising edge of the synchronized level. Reusable for any Wrapper button.
//
// Ports:
//   clock  - system clock
//   reset  - asynchronous, active-high; clears chain, edge flop and pulse
//   btn    - raw button input, asynchronous to clock
//   pulse  - one-cycle strobe, SYNC_STAGES+1 cycles after btn rises
// ---------------------------------------------------------------------------
module btn_sync_edge
    import regfile_scan_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   edge_q;

    // The pulse itself is registered so downstream logic sees a clean flop
    // output; edge_q remembers the previous synchronized level so a held
    // button produces exactly one pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync   <= '0;
            edge_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], btn};
            edge_q <= sync[SYNC_STAGES-1];
            pulse  <= sync[SYNC_STAGES-1] & ~edge_q;
        end
    end

endmodule

// File: rtl/regfile_scan_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_scan_ctrl
// Debug read-out of the processor register file through regfile port A.
// A button press starts a scan of indices 0..NUM_REGS-1; port A is shared
// with the core's rs1 decode, the core winning until the scan has been
// denied MAX_WAIT consecutive cycles, after which the scan takes the port
// and the core is stalled for that cycle. Each sampled register is streamed
// out as an {index, value} strobe.
//
// Ports:
//   clock, reset       - system clock, async active-high reset
//   start_btn          - raw scan-start push button
//   core_rs1           - core's port-A read index
//   core_rs1_req       - core needs port A this cycle
//   regA               - regfile port-A read data (combinational from rs1_in)
//   rs1_in             - index driven to regfile port A
//   core_stall         - core must hold its pipeline this cycle
//   dump_valid         - one-cycle strobe qualifying dump_idx/dump_data
//   dump_idx/dump_data - dumped register index and value
//   busy               - scan in progress (running or finishing)
//   done               - one-cycle pulse alongside the last dump strobe
// ---------------------------------------------------------------------------
module regfile_scan_ctrl
    import regfile_scan_ctrl_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int MAX_WAIT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_btn,
    input  logic [REG_IDX_W-1:0] core_rs1,
    input  logic                 core_rs1_req,
    input  logic [DATA_W-1:0]    regA,
    output logic [REG_IDX_W-1:0] rs1_in,
    output logic                 core_stall,
    output logic                 dump_valid,
    output logic [REG_IDX_W-1:0] dump_idx,
    output logic [DATA_W-1:0]    dump_data,
    output logic                 busy,
    output logic                 done
);

    localparam int                   WAIT_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0]    WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [REG_IDX_W-1:0] LAST_IDX   = REG_IDX_W'(NUM_REGS - 1);

    scan_state_t          state;
    logic [REG_IDX_W-1:0] idx;
    logic [WAIT_W-1:0]    wait_cnt;
    logic                 start_pulse;
    logic                 grant;

    btn_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_start_sync (
        .clock(clock),
        .reset(reset),
        .btn  (start_btn),
        .pulse(start_pulse)
    );

    // Port-A arbitration. The scan only ever owns the port while running;
    // it takes it whenever the core is not asking, or by force once it has
    // waited MAX_WAIT cycles in a row (MAX_WAIT=0 makes the scan always win).
    always_comb begin
        grant      = (state == SCAN_RUN) && (!core_rs1_req || (wait_cnt == WAIT_LIMIT));
        rs1_in     = grant ? idx : core_rs1;
        core_stall = core_rs1_req & grant;
        busy       = (state != SCAN_IDLE);
    end

    // Scan FSM with registered dump outputs. A granted cycle samples regA
    // for the current index; the final sample moves to DONE, whose single
    // cycle is where both done and the last dump_valid are visible.
    // dump_idx/dump_data are left untouched outside grants so they hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= SCAN_IDLE;
            idx        <= '0;
            wait_cnt   <= '0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                SCAN_IDLE: begin
                    dump_valid <= 1'b0;
                    done       <= 1'b0;
                    if (start_pulse) begin
                        state    <= SCAN_RUN;
                        idx      <= '0;
                        wait_cnt <= '0;
                    end
                end
                SCAN_RUN: begin
                    if (grant) begin
                        dump_valid <= 1'b1;
                        dump_idx   <= idx;
                        dump_data  <= regA;
                        wait_cnt   <= '0;
                        idx        <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= SCAN_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        dump_valid <= 1'b0;
                        if (wait_cnt != WAIT_LIMIT) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                SCAN_DONE: begin
                    dump_valid <= 1'b0;
                    done       <= 1'b0;
                    state      <= SCAN_IDLE;
                end
                default: begin
                    state <= SCAN_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_scan_ctrl
// Two controllers share clock, reset, button and core inputs: index 0 uses
// MAX_WAIT=4, index 1 uses MAX_WAIT=0. Each reads its own port of a common
// behavioural regfile. Every accepted button press pushes the expected
// {index, value, last} stream for an instance into its scoreboard queue;
// a negedge monitor pops and compares whenever dump_valid is seen.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_scan_ctrl;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        bit          last;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_btn;
    logic [4:0]  core_rs1;
    logic        core_rs1_req;

    logic [31:0] ra [2];
    logic [4:0]  ri [2];
    logic [4:0]  di [2];
    logic [31:0] dd [2];
    logic [1:0]  st;
    logic [1:0]  dv;
    logic [1:0]  bs;
    logic [1:0]  dn;

    logic [31:0] regs [32];

    exp_t sb [2][$];
    exp_t e;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int press_cyc = 0;
    int req_pct = 0;
    bit rand_mode = 1'b0;
    int done_cnt [2];
    int done_cyc [2];
    int stall_cnt [2];
    int exp_first [2];
    int exp_gap [2];
    int prev_cyc [2];
    bit first_pend [2];

    assign ra[0] = regs[ri[0]];
    assign ra[1] = regs[ri[1]];

    regfile_scan_ctrl #(.NUM_REGS(32), .MAX_WAIT(4), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .start_btn(start_btn),
        .core_rs1(core_rs1), .core_rs1_req(core_rs1_req), .regA(ra[0]),
        .rs1_in(ri[0]), .core_stall(st[0]), .dump_valid(dv[0]),
        .dump_idx(di[0]), .dump_data(dd[0]), .busy(bs[0]), .done(dn[0])
    );

    regfile_scan_ctrl #(.NUM_REGS(32), .MAX_WAIT(0), .SYNC_STAGES(2)) dut_w0 (
        .clock(clock), .reset(reset), .start_btn(start_btn),
        .core_rs1(core_rs1), .core_rs1_req(core_rs1_req), .regA(ra[1]),
        .rs1_in(ri[1]), .core_stall(st[1]), .dump_valid(dv[1]),
        .dump_idx(di[1]), .dump_data(dd[1]), .busy(bs[1]), .done(dn[1])
    );

    // Free-running clock and a cycle counter used for latency and gap checks.
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Hard stop in case something hangs beyond every per-wait bound.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each strobe and checks the per-cycle
    // arbitration rules against the expected next index of the scan.
    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (dv[k]) begin
                    if (sb[k].size() == 0) begin
                        checkOutput($sformatf("unexpected_strobe%0d", k), 1, 0);
                    end else begin
                        e = sb[k].pop_front();
                        checkOutput($sformatf("dump_idx%0d", k), di[k], e.idx);
                        checkOutput($sformatf("dump_data%0d", k), dd[k], e.data);
                        checkOutput($sformatf("done_on_last%0d", k), dn[k], e.last);
                        if (first_pend[k]) begin
                            if (exp_first[k] != 0)
                                checkOutput($sformatf("first_latency%0d", k), cyc - press_cyc, exp_first[k]);
                            first_pend[k] = 1'b0;
                        end else if (exp_gap[k] != 0) begin
                            checkOutput($sformatf("strobe_gap%0d", k), cyc - prev_cyc[k], exp_gap[k]);
                        end
                        prev_cyc[k] = cyc;
                    end
                end else if (dn[k]) begin
                    checkOutput($sformatf("done_without_strobe%0d", k), 1, 0);
                end
                if (dn[k]) begin
                    done_cnt[k]++;
                    done_cyc[k] = cyc;
                end
                if (st[k]) stall_cnt[k]++;
                if (bs[k] && !dn[k] && (st[k] || !core_rs1_req)) begin
                    if (sb[k].size() == 0)
                        checkOutput($sformatf("scan_without_expectation%0d", k), 1, 0);
                    else
                        checkOutput($sformatf("scan_rs1%0d", k), ri[k], sb[k][0].idx);
                end else begin
                    checkOutput($sformatf("core_rs1_pass%0d", k), ri[k], core_rs1);
                end
                if (!bs[k] || dn[k]) checkOutput($sformatf("stall_not_scanning%0d", k), st[k], 0);
                if (k == 1) checkOutput("stall_w0", st[1], bs[1] && !dn[1] && core_rs1_req);
                else if (st[0]) checkOutput("stall_needs_req", core_rs1_req, 1);
            end
        end
    end

    // One cycle step; inputs change just after the negedge so the monitor
    // and the DUT both see them stable around the next posedge.
    task automatic tick();
        @(negedge clock);
        #1;
        if (rand_mode) begin
            core_rs1     = 5'($urandom_range(0, 31));
            core_rs1_req = ($urandom_range(0, 99) < req_pct);
        end
    endtask

    task automatic pushScan(input int k);
        for (int i = 0; i < 32; i++) begin
            sb[k].push_back('{idx: i[4:0], data: regs[i], last: (i == 31)});
        end
        first_pend[k] = 1'b1;
    endtask

    task automatic applyStimulus(input int hold, input bit acc0, input bit acc1);
        start_btn = 1'b1;
        press_cyc = cyc;
        if (acc0) pushScan(0);
        if (acc1) pushScan(1);
        repeat (hold) tick();
        start_btn = 1'b0;
    endtask

    task automatic waitDone(input int t0, input int t1, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            if (done_cnt[0] >= t0 && done_cnt[1] >= t1) ok = 1'b1;
        end
        checkOutput("scan_completes", ok, 1);
    endtask

    task automatic waitIdx(input logic [4:0] target, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            if (dv[0] && di[0] == target) ok = 1'b1;
        end
        checkOutput("reach_idx", ok, 1);
    endtask

    task automatic checkQueuesEmpty();
        checkOutput("queue_empty0", sb[0].size(), 0);
        checkOutput("queue_empty1", sb[1].size(), 0);
    endtask

    task automatic checkAllZero(input string tag);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s_dump_valid%0d", tag, k), dv[k], 0);
            checkOutput($sformatf("%s_dump_idx%0d", tag, k), di[k], 0);
            checkOutput($sformatf("%s_dump_data%0d", tag, k), dd[k], 0);
            checkOutput($sformatf("%s_done%0d", tag, k), dn[k], 0);
            checkOutput($sformatf("%s_busy%0d", tag, k), bs[k], 0);
            checkOutput($sformatf("%s_stall%0d", tag, k), st[k], 0);
        end
    endtask

    initial begin
        int d0;
        int d1;
        reset        = 1'b1;
        start_btn    = 1'b0;
        core_rs1     = 5'd0;
        core_rs1_req = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
        for (int k = 0; k < 2; k++) begin
            done_cnt[k] = 0; done_cyc[k] = 0; stall_cnt[k] = 0;
            exp_first[k] = 5; exp_gap[k] = 1; prev_cyc[k] = 0; first_pend[k] = 1'b0;
        end

        // Reset state.
        repeat (3) tick();
        checkAllZero("reset");
        reset = 1'b0;
        repeat (3) tick();

        // Uncontended scan, rN = 3N, button held 5 cycles.
        stall_cnt[0] = 0; stall_cnt[1] = 0;
        d0 = done_cnt[0]; d1 = done_cnt[1];
        applyStimulus(5, 1'b1, 1'b1);
        waitDone(d0 + 1, d1 + 1, 100);
        checkOutput("uncontended_done_cycle", done_cyc[0] - press_cyc, 36);
        tick();
        checkOutput("busy_after_done", bs[0], 0);
        checkOutput("uncontended_stalls", stall_cnt[0], 0);
        checkQueuesEmpty();
        repeat (5) tick();

        // Core holds port A with rs1=7: forced grant every 5th cycle;
        // the MAX_WAIT=0 instance wins every cycle and stalls 32 times.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        core_rs1 = 5'd7; core_rs1_req = 1'b1;
        exp_first[0] = 9; exp_gap[0] = 5;
        repeat (2) tick();
        stall_cnt[0] = 0; stall_cnt[1] = 0;
        d0 = done_cnt[0]; d1 = done_cnt[1];
        applyStimulus(5, 1'b1, 1'b1);
        waitDone(d0 + 1, d1 + 1, 300);
        checkOutput("contended_done_cycle", done_cyc[0] - press_cyc, 164);
        checkOutput("w0_done_cycle", done_cyc[1] - press_cyc, 36);
        tick();
        checkOutput("busy_after_contended", bs[0], 0);
        checkOutput("contended_stalls", stall_cnt[0], 32);
        checkOutput("w0_stalls", stall_cnt[1], 32);
        checkQueuesEmpty();
        core_rs1_req = 1'b0;
        exp_first[0] = 5; exp_gap[0] = 1;
        repeat (5) tick();

        // Second press mid-scan is ignored.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        d0 = done_cnt[0]; d1 = done_cnt[1];
        applyStimulus(3, 1'b1, 1'b1);
        waitIdx(5'd10, 60);
        applyStimulus(3, 1'b0, 1'b0);
        waitDone(d0 + 1, d1 + 1, 100);
        repeat (40) tick();
        checkOutput("single_done0", done_cnt[0], d0 + 1);
        checkOutput("single_done1", done_cnt[1], d1 + 1);
        checkQueuesEmpty();

        // Asynchronous reset mid-scan, then a clean restart.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        applyStimulus(3, 1'b1, 1'b1);
        waitIdx(5'd15, 60);
        #3;
        reset = 1'b1;
        #1;
        checkAllZero("midreset");
        sb[0].delete(); sb[1].delete();
        first_pend[0] = 1'b0; first_pend[1] = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        d0 = done_cnt[0]; d1 = done_cnt[1];
        repeat (40) tick();
        checkOutput("no_done_after_reset0", done_cnt[0], d0);
        checkOutput("no_done_after_reset1", done_cnt[1], d1);
        applyStimulus(3, 1'b1, 1'b1);
        waitDone(d0 + 1, d1 + 1, 100);
        repeat (5) tick();
        checkQueuesEmpty();

        // Button bounce 1-0-1 while idle starts one scan only.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        d0 = done_cnt[0]; d1 = done_cnt[1];
        start_btn = 1'b1;
        press_cyc = cyc;
        pushScan(0); pushScan(1);
        tick();
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        repeat (4) tick();
        start_btn = 1'b0;
        waitDone(d0 + 1, d1 + 1, 100);
        repeat (40) tick();
        checkOutput("bounce_done0", done_cnt[0], d0 + 1);
        checkOutput("bounce_done1", done_cnt[1], d1 + 1);
        checkQueuesEmpty();

        // Randomized core traffic against randomized regfile contents.
        rand_mode = 1'b1;
        exp_first[0] = 0; exp_gap[0] = 0;
        for (int s = 0; s < 5; s++) begin
            req_pct = $urandom_range(0, 100);
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            d0 = done_cnt[0]; d1 = done_cnt[1];
            applyStimulus(4, 1'b1, 1'b1);
            waitDone(d0 + 1, d1 + 1, 32 * 5 + 40);
            repeat (8) tick();
            checkQueuesEmpty();
        end
        rand_mode = 1'b0;
        core_rs1_req = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
